mult_ctrl: RTL and testbench

MULT_CTRL -- requirements
Module: mult_ctrl

---
 rtl/mult_ctrl.sv | 171 +++++++++++++++++
 tb/tb_mult_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_ctrl.sv
// mult_ctrl: sequential signed multiplier controller (radix-2 Booth).
// One Booth step per clock; the add/subtract of each step is performed by an
// external shared CLA adder through add_a/add_b/add_cin -> add_sum.
// Optional feature: define MULT_OVF_EN to add the ovf output, which flags a
// product that does not fit in WIDTH signed bits.
module mult_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  output logic [WIDTH-1:0] result,
  output logic             ready,
  output logic             busy
`ifdef MULT_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;

  // Booth working registers: multiplicand M and product register {hi, lo, q}.
  logic [WIDTH-1:0]   m_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               q_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   res_q;

  logic               accept;
  logic               last_iter;
  logic               do_sub;
  logic               do_op;
  logic [WIDTH-1:0]   hi_acc;
  logic               acc_sign;
  logic [WIDTH-1:0]   hi_shift;
  logic [WIDTH-1:0]   lo_shift;
  logic               q_shift;

  // A new operation can start from IDLE or DONE; start is ignored in RUN.
  assign accept    = start && (state != RUN);
  assign last_iter = (cnt_q == LAST_ITER);

  // Booth pair {lo[0], q}: 10 subtracts M, 01 adds M, 00/11 leave hi alone.
  assign do_sub = (state == RUN) && lo_q[0] && !q_q;
  assign do_op  = (state == RUN) && (lo_q[0] ^ q_q);

  // Shared adder operands: add hi+M by default so the adder never floats.
  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    add_a   = hi_q;
    add_b   = m_q;
    add_cin = 1'b0;
    if (do_sub) begin
      add_b   = ~m_q;
      add_cin = 1'b1;
    end
  end

  // Accumulate and arithmetic-shift {hi, lo, q} right by one.
  // The sum of hi and +/-M needs WIDTH+1 bits when it overflows (e.g. when
  // subtracting the most negative M), so the bit shifted into hi[WIDTH-1] is
  // the true sign of the sum: the common operand sign when both operands agree,
  // otherwise the sign bit of the WIDTH-bit sum. Without this the high half,
  // and hence the overflow flag, would be wrong.
  always_comb begin
    hi_acc   = hi_q;
    acc_sign = hi_q[WIDTH-1];
    if (do_op) begin
      hi_acc   = add_sum;
      acc_sign = (hi_q[WIDTH-1] == add_b[WIDTH-1]) ? hi_q[WIDTH-1]
                                                   : add_sum[WIDTH-1];
    end
    hi_shift = {acc_sign, hi_acc[WIDTH-1:1]};
    lo_shift = {hi_acc[0], lo_q[WIDTH-1:1]};
    q_shift  = lo_q[0];
  end

  // Next-state logic of the IDLE/RUN/DONE controller.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Booth datapath: load on accepted start, one step per RUN cycle.
  // NOTE: every datapath register is cleared by reset, so the adder operands
  // and result read as zero while reset is held.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      q_q   <= 1'b0;
      cnt_q <= '0;
    end else if (accept) begin
      m_q   <= op_a;
      hi_q  <= '0;
      lo_q  <= op_b;
      q_q   <= 1'b0;
      cnt_q <= '0;
    end else if (state == RUN) begin
      hi_q  <= hi_shift;
      lo_q  <= lo_shift;
      q_q   <= q_shift;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Result capture on the final step; held through DONE and IDLE.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      res_q <= '0;
    end else if ((state == RUN) && last_iter) begin
      res_q <= lo_shift;
    end
  end

`ifdef MULT_OVF_EN
  logic ovf_q;

  // Overflow flag: the high half must be pure sign extension of the low half.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ovf_q <= 1'b0;
    end else if ((state == RUN) && last_iter) begin
      ovf_q <= (hi_shift != {WIDTH{lo_shift[WIDTH-1]}});
    end
  end

  assign ovf = ovf_q;
`endif

  assign result = res_q;
  assign ready  = (state == DONE);
  assign busy   = (state == RUN);

endmodule

// File: tb/tb_mult_ctrl.sv
// tb_mult_ctrl: self-checking bench for mult_ctrl (WIDTH=32).
// Provides the shared adder behaviourally; expected products come from a
// table of hand-computed constants and from 64-bit signed arithmetic.
// Builds with or without MULT_OVF_EN; ovf is checked only when present.
module tb_mult_ctrl;

  localparam int W   = 32;
  localparam int LAT = W;  // ready seen W cycles after the accepting edge

  logic         clock;
  logic         resetn;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic         add_cin;
  logic [W-1:0] add_sum;
  logic [W-1:0] result;
  logic         ready;
  logic         busy;
`ifdef MULT_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mult_ctrl #(.WIDTH(W)) dut (
    .clock   (clock),
    .resetn  (resetn),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_cin (add_cin),
    .add_sum (add_sum),
    .result  (result),
    .ready   (ready),
    .busy    (busy)
`ifdef MULT_OVF_EN
    ,
    .ovf     (ovf)
`endif
  );

  // Shared CLA adder, modelled behaviourally.
  assign add_sum = add_a + add_b + {{(W-1){1'b0}}, add_cin};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    longint pa, pb, p, lo_ext;
    logic [63:0] pbits;
    logic [W-1:0] lo;
    pa     = longint'($signed(a));
    pb     = longint'($signed(b));
    p      = pa * pb;
    pbits  = p;
    lo     = pbits[W-1:0];
    lo_ext = longint'($signed(lo));
    return {(p != lo_ext), lo};
  endfunction

  function automatic logic get_ovf();
`ifdef MULT_OVF_EN
    return ovf;
`else
    return 1'b0;
`endif
  endfunction

  // Run one operation with a one-cycle start; returns result, ovf, latency.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag,
                       output logic [W-1:0] res, output logic ov, output int lat);
    int busy_n;
    busy_n = 0;
    lat    = -1;
    @(negedge clock);
    start = 1'b1; op_a = a; op_b = b;
    @(negedge clock);
    start = 1'b0; op_a = $urandom; op_b = $urandom;
    for (int k = 0; k < 100; k++) begin
      if (k > 0) @(negedge clock);
      if (busy) busy_n++;
      if (ready) begin
        lat = k;
        break;
      end
    end
    res = result;
    ov  = get_ovf();
    check({tag, " latency"}, 64'(lat), 64'(LAT));
    check({tag, " busy cycles"}, 64'(busy_n), 64'(LAT));
    @(negedge clock);
    check({tag, " ready one cycle"}, 64'(ready), 64'd0);
    check({tag, " idle busy"}, 64'(busy), 64'd0);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         ov;
  } vec_t;

  initial begin
    vec_t         vecs[$];
    logic [W-1:0] r;
    logic         o;
    int           lat;
    logic [W:0]   m;

    resetn = 1'b0; start = 1'b0; op_a = '0; op_b = '0;

    // Reset state.
    repeat (2) @(negedge clock);
    check("rst result", 64'(result), 64'd0);
    check("rst ready", 64'(ready), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst add_a", 64'(add_a), 64'd0);
    check("rst add_b", 64'(add_b), 64'd0);
    check("rst add_cin", 64'(add_cin), 64'd0);
`ifdef MULT_OVF_EN
    check("rst ovf", 64'(ovf), 64'd0);
`endif
    resetn = 1'b1;
    @(negedge clock);
    check("idle busy after rst", 64'(busy), 64'd0);

    // Directed vectors with hand-computed products.
    vecs.push_back('{32'd3,        32'd5,        32'h0000000F, 1'b0});
    vecs.push_back('{32'hFFFFFFF9, 32'd6,        32'hFFFFFFD6, 1'b0});
    vecs.push_back('{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1});
    vecs.push_back('{32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE, 1'b1});
    vecs.push_back('{32'd0,        32'h12345678, 32'h00000000, 1'b0});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0});
    vecs.push_back('{32'h80000000, 32'h80000000, 32'h00000000, 1'b1});
    vecs.push_back('{32'h00010000, 32'h00010000, 32'h00000000, 1'b1});
    vecs.push_back('{32'hFFFF0000, 32'h00008000, 32'h80000000, 1'b0});
    vecs.push_back('{32'h80000000, 32'd1,        32'h80000000, 1'b0});
    vecs.push_back('{32'd1,        32'h80000000, 32'h80000000, 1'b0});

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, $sformatf("vec%0d", i), r, o, lat);
      check($sformatf("vec%0d result", i), 64'(r), 64'(vecs[i].res));
`ifdef MULT_OVF_EN
      check($sformatf("vec%0d ovf", i), 64'(o), 64'(vecs[i].ov));
`endif
      repeat (2) @(negedge clock);
      check($sformatf("vec%0d result held", i), 64'(result), 64'(vecs[i].res));
`ifdef MULT_OVF_EN
      check($sformatf("vec%0d ovf held", i), 64'(ovf), 64'(vecs[i].ov));
`endif
    end

    // Start re-asserted mid-RUN is ignored: 100 * -3 = -300.
    begin
      int lt;
      lt = -1;
      @(negedge clock);
      start = 1'b1; op_a = 32'd100; op_b = 32'hFFFFFFFD;
      @(negedge clock);
      start = 1'b0;
      for (int k = 0; k < 100; k++) begin
        if (k > 0) @(negedge clock);
        if (k == 10) begin start = 1'b1; op_a = 32'd9; op_b = 32'd9; end
        if (k == 11) start = 1'b0;
        if (ready) begin lt = k; break; end
      end
      check("restart latency", 64'(lt), 64'(LAT));
      check("restart result", 64'(result), 64'hFFFFFED4);
    end

    // Reset during RUN aborts without a ready pulse.
    begin
      int pulses;
      pulses = 0;
      @(negedge clock);
      start = 1'b1; op_a = 32'h1234; op_b = 32'h10;
      @(negedge clock);
      start = 1'b0;
      repeat (15) @(negedge clock);
      check("pre-abort busy", 64'(busy), 64'd1);
      resetn = 1'b0;
      #1;
      check("abort busy", 64'(busy), 64'd0);
      check("abort ready", 64'(ready), 64'd0);
      check("abort result", 64'(result), 64'd0);
      check("abort add_a", 64'(add_a), 64'd0);
      check("abort add_b", 64'(add_b), 64'd0);
      check("abort add_cin", 64'(add_cin), 64'd0);
      @(negedge clock);
      resetn = 1'b1;
      for (int k = 0; k < 40; k++) begin
        @(negedge clock);
        if (ready || busy) pulses++;
      end
      check("abort no ready/busy", 64'(pulses), 64'd0);
      do_op(32'd4, 32'd4, "post-abort", r, o, lat);
      check("post-abort result", 64'(r), 64'h00000010);
    end

    // Start held through DONE: back-to-back operations 33 cycles apart.
    begin
      logic [W-1:0] ba[3];
      logic [W-1:0] bb[3];
      logic [W-1:0] bres[3];
      int           t_rdy[3];
      int           n;
      ba = '{32'd6, 32'hFFFFFFFE, 32'h00010000};
      bb = '{32'd7, 32'd50,       32'd3};
      n = 0;
      @(negedge clock);
      start = 1'b1; op_a = ba[0]; op_b = bb[0];
      for (int t = 1; t <= 200 && n < 3; t++) begin
        @(negedge clock);
        if (ready) begin
          t_rdy[n] = t;
          bres[n]  = result;
          n++;
          if (n < 3) begin op_a = ba[n]; op_b = bb[n]; end
          else start = 1'b0;
        end
      end
      check("b2b count", 64'(n), 64'd3);
      if (n == 3) begin
        check("b2b first ready", 64'(t_rdy[0]), 64'd33);
        check("b2b gap 1", 64'(t_rdy[1] - t_rdy[0]), 64'd33);
        check("b2b gap 2", 64'(t_rdy[2] - t_rdy[1]), 64'd33);
        for (int i = 0; i < 3; i++) begin
          m = model(ba[i], bb[i]);
          check($sformatf("b2b result %0d", i), 64'(bres[i]), 64'(m[W-1:0]));
        end
      end
      start = 1'b0;
      @(negedge clock);
      check("b2b idle ready", 64'(ready), 64'd0);
      check("b2b idle busy", 64'(busy), 64'd0);
    end

    // Random operands against the arithmetic model.
    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] a, b;
      a = $urandom;
      b = $urandom;
      if (i % 4 == 1) a = W'($signed(16'($urandom)));
      if (i % 4 == 2) b = W'($signed(16'($urandom)));
      m = model(a, b);
      do_op(a, b, $sformatf("rnd%0d", i), r, o, lat);
      check($sformatf("rnd%0d result a=%0h b=%0h", i, a, b), 64'(r), 64'(m[W-1:0]));
`ifdef MULT_OVF_EN
      check($sformatf("rnd%0d ovf", i), 64'(o), 64'(m[W]));
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
